// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous memory between a fetch
// (read-only) port and a data (read/write) port. One transaction is in
// flight at a time: IDLE grants, BUS presents the access to memory, and WAIT
// collects read data one cycle after the memory sampled the address.
// Memory-side outputs, read-data holding registers and done pulses are all
// registered.
module mem_arbiter #(
   parameter int PRIORITY = 0   // 0 = round-robin on ties, 1 = data port wins ties
) (
   input  logic       clk,
   input  logic       rst,
   // fetch port
   input  logic       f_req,
   input  logic [7:0] f_addr,
   output logic [7:0] f_rdata,
   output logic       f_done,
   // data port
   input  logic       d_req,
   input  logic       d_we,
   input  logic [7:0] d_addr,
   input  logic [7:0] d_wdata,
   output logic [7:0] d_rdata,
   output logic       d_done,
   // memory side
   output logic [7:0] addr,
   output logic [7:0] data_out,
   output logic       we,
   input  logic [7:0] data_in,
   // status
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;

   // owner_data: 1 when the in-flight transaction belongs to the data port
   logic       owner_data;
   logic       owner_data_nxt;
   // last_data: 1 when the most recent grant went to the data port
   logic       last_data;
   logic       last_data_nxt;

   logic [7:0] addr_nxt;
   logic [7:0] data_out_nxt;
   logic       we_nxt;
   logic       f_done_nxt;
   logic       d_done_nxt;
   logic [7:0] f_rdata_nxt;
   logic [7:0] d_rdata_nxt;

   logic       f_elig;
   logic       d_elig;
   logic       grant_data;

   // A port whose done pulse is showing this cycle is not allowed to be
   // granted again on the same edge; the other port may still win it.
   assign f_elig = f_req & ~f_done;
   assign d_elig = d_req & ~d_done;

   assign busy = (state != IDLE);

   // Winner selection among the eligible requesters (only consulted in IDLE).
   always_comb begin
      grant_data = 1'b0;
      if (d_elig && f_elig) begin
         if (PRIORITY != 0) begin
            grant_data = 1'b1;
         end else begin
            grant_data = ~last_data;
         end
      end else if (d_elig) begin
         grant_data = 1'b1;
      end
   end

   // Next-state and next-output logic; everything holds unless a state acts on it.
   always_comb begin
      state_nxt      = state;
      owner_data_nxt = owner_data;
      last_data_nxt  = last_data;
      addr_nxt       = addr;
      data_out_nxt   = data_out;
      we_nxt         = we;
      f_done_nxt     = 1'b0;
      d_done_nxt     = 1'b0;
      f_rdata_nxt    = f_rdata;
      d_rdata_nxt    = d_rdata;

      case (state)
         IDLE: begin
            if (f_elig || d_elig) begin
               owner_data_nxt = grant_data;
               last_data_nxt  = grant_data;
               addr_nxt       = grant_data ? d_addr : f_addr;
               we_nxt         = grant_data & d_we;
               data_out_nxt   = d_wdata;
               state_nxt      = BUS;
            end
         end

         BUS: begin
            // Memory samples addr/we on this edge; a write is finished here,
            // a read still needs one more cycle for data_in to arrive.
            we_nxt = 1'b0;
            if (we) begin
               d_done_nxt = 1'b1;
               state_nxt  = IDLE;
            end else begin
               state_nxt  = WAIT;
            end
         end

         WAIT: begin
            if (owner_data) begin
               d_rdata_nxt = data_in;
               d_done_nxt  = 1'b1;
            end else begin
               f_rdata_nxt = data_in;
               f_done_nxt  = 1'b1;
            end
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            we_nxt    = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any in-flight transaction
   // and leaves the fetch port favoured for the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner_data <= 1'b0;
         last_data  <= 1'b1;
         addr       <= 8'h00;
         data_out   <= 8'h00;
         we         <= 1'b0;
         f_done     <= 1'b0;
         d_done     <= 1'b0;
         f_rdata    <= 8'h00;
         d_rdata    <= 8'h00;
      end else begin
         state      <= state_nxt;
         owner_data <= owner_data_nxt;
         last_data  <= last_data_nxt;
         addr       <= addr_nxt;
         data_out   <= data_out_nxt;
         we         <= we_nxt;
         f_done     <= f_done_nxt;
         d_done     <= d_done_nxt;
         f_rdata    <= f_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Two instances share the
// request stimulus, one round-robin (dut_rr) and one fixed-priority (dut_fp),
// each with its own memory. Memory is preloaded on reset with
// mem[i] = i ^ 8'hB5, so e.g. mem[8'h10] = 8'hA5, mem[8'h60] = 8'hD5,
// mem[8'h70] = 8'hC5.
module tb_mem_arbiter;

   logic       clk;
   logic       rst;
   logic       f_req;
   logic [7:0] f_addr;
   logic       d_req;
   logic       d_we;
   logic [7:0] d_addr;
   logic [7:0] d_wdata;

   logic [7:0] f_rdata_rr, d_rdata_rr, addr_rr, data_out_rr, data_in_rr;
   logic       f_done_rr, d_done_rr, we_rr, busy_rr;
   logic [7:0] f_rdata_fp, d_rdata_fp, addr_fp, data_out_fp, data_in_fp;
   logic       f_done_fp, d_done_fp, we_fp, busy_fp;

   logic [7:0] mem_rr [0:255];
   logic [7:0] mem_fp [0:255];

   int n_cmp;
   int n_bad;

   mem_arbiter #(.PRIORITY(0)) dut_rr (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata_rr), .f_done(f_done_rr),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_rr), .d_done(d_done_rr),
      .addr(addr_rr), .data_out(data_out_rr), .we(we_rr), .data_in(data_in_rr),
      .busy(busy_rr)
   );

   mem_arbiter #(.PRIORITY(1)) dut_fp (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata_fp), .f_done(f_done_fp),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_fp), .d_done(d_done_fp),
      .addr(addr_fp), .data_out(data_out_fp), .we(we_fp), .data_in(data_in_fp),
      .busy(busy_fp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory models: write on we, read data one cycle after addr.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_rr[i] <= 8'(i) ^ 8'hB5;
      end else if (we_rr) begin
         mem_rr[addr_rr] <= data_out_rr;
      end
      data_in_rr <= mem_rr[addr_rr];
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_fp[i] <= 8'(i) ^ 8'hB5;
      end else if (we_fp) begin
         mem_fp[addr_fp] <= data_out_fp;
      end
      data_in_fp <= mem_fp[addr_fp];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      f_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      n_cmp++; if (addr_rr !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_addr got %h want 00", addr_rr); end
      n_cmp++; if (data_out_rr !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_data_out got %h want 00", data_out_rr); end
      n_cmp++; if (we_rr !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_we got %b want 0", we_rr); end
      n_cmp++; if ({f_done_rr, d_done_rr} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_dones got %b want 00", {f_done_rr, d_done_rr}); end
      n_cmp++; if ({f_rdata_rr, d_rdata_rr} !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_rdata got %h want 0000", {f_rdata_rr, d_rdata_rr}); end
      n_cmp++; if (busy_rr !== 1'b0 || busy_fp !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b%b want 00", busy_rr, busy_fp); end
   endtask

   task automatic test_fetch_read;
      do_reset;
      f_req = 1'b1; f_addr = 8'h10;
      tick;  // grant edge
      n_cmp++; if (addr_rr !== 8'h10 || busy_rr !== 1'b1) begin n_bad++; $display("[TB] FAIL fetch_grant got addr=%h busy=%b want addr=10 busy=1", addr_rr, busy_rr); end
      n_cmp++; if (we_rr !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_we_bus got %b want 0", we_rr); end
      f_req = 1'b0; f_addr = 8'h77;
      tick;  // BUS edge
      n_cmp++; if (f_done_rr !== 1'b0 || we_rr !== 1'b0 || busy_rr !== 1'b1) begin n_bad++; $display("[TB] FAIL fetch_wait got done=%b we=%b busy=%b want 0 0 1", f_done_rr, we_rr, busy_rr); end
      tick;  // WAIT edge
      n_cmp++; if (f_done_rr !== 1'b1 || f_rdata_rr !== 8'hA5) begin n_bad++; $display("[TB] FAIL fetch_done got done=%b rdata=%h want 1 A5", f_done_rr, f_rdata_rr); end
      n_cmp++; if (d_done_rr !== 1'b0 || busy_rr !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_idle got d_done=%b busy=%b want 0 0", d_done_rr, busy_rr); end
      tick;
      n_cmp++; if (f_done_rr !== 1'b0 || f_rdata_rr !== 8'hA5 || addr_rr !== 8'h10) begin n_bad++; $display("[TB] FAIL fetch_hold got done=%b rdata=%h addr=%h want 0 A5 10", f_done_rr, f_rdata_rr, addr_rr); end
   endtask

   task automatic test_data_write;
      do_reset;
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
      tick;
      n_cmp++; if (we_rr !== 1'b1 || addr_rr !== 8'h20 || data_out_rr !== 8'h3C) begin n_bad++; $display("[TB] FAIL write_bus got we=%b addr=%h data=%h want 1 20 3C", we_rr, addr_rr, data_out_rr); end
      n_cmp++; if (d_done_rr !== 1'b0) begin n_bad++; $display("[TB] FAIL write_early_done got %b want 0", d_done_rr); end
      d_req = 1'b0; d_addr = 8'h99; d_wdata = 8'hEE;
      tick;
      n_cmp++; if (d_done_rr !== 1'b1 || we_rr !== 1'b0 || f_done_rr !== 1'b0) begin n_bad++; $display("[TB] FAIL write_done got d_done=%b we=%b f_done=%b want 1 0 0", d_done_rr, we_rr, f_done_rr); end
      n_cmp++; if (mem_rr[8'h20] !== 8'h3C) begin n_bad++; $display("[TB] FAIL write_mem got %h want 3C", mem_rr[8'h20]); end
      tick;
      n_cmp++; if (d_done_rr !== 1'b0 || busy_rr !== 1'b0 || addr_rr !== 8'h20) begin n_bad++; $display("[TB] FAIL write_after got d_done=%b busy=%b addr=%h want 0 0 20", d_done_rr, busy_rr, addr_rr); end
   endtask

   task automatic test_round_robin;
      int owners_rr [0:15];
      int n_rr;
      int first_fp;
      logic prev_f, prev_d;
      do_reset;
      f_req = 1'b1; f_addr = 8'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
      n_rr = 0; first_fp = 0; prev_f = 1'b0; prev_d = 1'b0;
      for (int i = 0; i < 24; i++) begin
         tick;
         n_cmp++; if (f_done_rr && d_done_rr) begin n_bad++; $display("[TB] FAIL rr_both_done cycle %0d got 11 want not both", i); end
         n_cmp++; if ((f_done_rr && prev_f) || (d_done_rr && prev_d)) begin n_bad++; $display("[TB] FAIL rr_pulse_width cycle %0d got two-cycle done want one", i); end
         prev_f = f_done_rr; prev_d = d_done_rr;
         if ((f_done_rr || d_done_rr) && n_rr < 16) begin
            owners_rr[n_rr] = f_done_rr ? 1 : 2;
            n_rr++;
         end
         if (first_fp == 0 && (f_done_fp || d_done_fp)) first_fp = d_done_fp ? 2 : 1;
      end
      n_cmp++; if (n_rr != 8) begin n_bad++; $display("[TB] FAIL rr_count got %0d want 8", n_rr); end
      for (int k = 0; k < 8 && k < n_rr; k++) begin
         n_cmp++; if (owners_rr[k] != ((k % 2 == 0) ? 1 : 2)) begin n_bad++; $display("[TB] FAIL rr_order slot %0d got %0d want %0d (1=F 2=D)", k, owners_rr[k], (k % 2 == 0) ? 1 : 2); end
      end
      n_cmp++; if (first_fp != 2) begin n_bad++; $display("[TB] FAIL fp_first_tie got %0d want 2 (1=F 2=D)", first_fp); end
      f_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_fixed_priority;
      do_reset;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h50;
      tick;
      d_req = 1'b0;
      tick; tick; tick;
      // last owner is now data; a tie must still go to data on the fixed-priority instance
      f_req = 1'b1; f_addr = 8'h60;
      d_req = 1'b1; d_addr = 8'h70;
      tick;
      n_cmp++; if (addr_fp !== 8'h70) begin n_bad++; $display("[TB] FAIL fp_tie_grant got addr=%h want 70", addr_fp); end
      n_cmp++; if (addr_rr !== 8'h60) begin n_bad++; $display("[TB] FAIL rr_tie_grant got addr=%h want 60", addr_rr); end
      d_req = 1'b0;
      tick; tick;
      n_cmp++; if (d_done_fp !== 1'b1 || f_done_fp !== 1'b0 || d_rdata_fp !== 8'hC5) begin n_bad++; $display("[TB] FAIL fp_data_done got d=%b f=%b rdata=%h want 1 0 C5", d_done_fp, f_done_fp, d_rdata_fp); end
      tick;
      n_cmp++; if (addr_fp !== 8'h60 || busy_fp !== 1'b1) begin n_bad++; $display("[TB] FAIL fp_fetch_grant got addr=%h busy=%b want 60 1", addr_fp, busy_fp); end
      f_req = 1'b0;
      tick; tick;
      n_cmp++; if (f_done_fp !== 1'b1 || f_rdata_fp !== 8'hD5) begin n_bad++; $display("[TB] FAIL fp_fetch_done got done=%b rdata=%h want 1 D5", f_done_fp, f_rdata_fp); end
   endtask

   task automatic test_reset_mid_read;
      int stray;
      do_reset;
      f_req = 1'b1; f_addr = 8'h10;
      tick;  // grant
      f_req = 1'b0;
      tick;  // now in WAIT
      n_cmp++; if (busy_rr !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_read_in_wait got busy=%b want 1", busy_rr); end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      n_cmp++; if (busy_rr !== 1'b0 || we_rr !== 1'b0 || f_done_rr !== 1'b0 || f_rdata_rr !== 8'h00) begin n_bad++; $display("[TB] FAIL mid_read_reset got busy=%b we=%b done=%b rdata=%h want 0 0 0 00", busy_rr, we_rr, f_done_rr, f_rdata_rr); end
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (f_done_rr || d_done_rr || busy_rr) stray++;
      end
      n_cmp++; if (stray != 0) begin n_bad++; $display("[TB] FAIL mid_read_stray got %0d active cycles want 0", stray); end
   endtask

   task automatic test_done_masking;
      int we_cnt;
      int done_cnt;
      do_reset;
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_wdata = 8'h11;
      we_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (we_rr) we_cnt++;
         if (d_done_rr) done_cnt++;
         if (i == 2) begin
            n_cmp++; if (busy_rr !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_no_grant got busy=%b want 0", busy_rr); end
            d_wdata = 8'h22;
         end
         if (i == 3) begin
            n_cmp++; if (we_rr !== 1'b1 || data_out_rr !== 8'h22) begin n_bad++; $display("[TB] FAIL mask_regrant got we=%b data=%h want 1 22", we_rr, data_out_rr); end
            d_req = 1'b0;
         end
      end
      n_cmp++; if (we_cnt != 2 || done_cnt != 2) begin n_bad++; $display("[TB] FAIL mask_count got we=%0d done=%0d want 2 2", we_cnt, done_cnt); end
      n_cmp++; if (mem_rr[8'h80] !== 8'h22) begin n_bad++; $display("[TB] FAIL mask_mem got %h want 22", mem_rr[8'h80]); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      f_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
      test_reset;
      test_fetch_read;
      test_data_write;
      test_round_robin;
      test_fixed_priority;
      test_reset_mid_read;
      test_done_masking;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
